// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two ROM requesters, the arbiter and the program ROM.
// Port names follow the board-level pinout; master is the requester/ROM side, slave is the arbiter.
interface rom_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  REQ0;
    logic [ADDR_WIDTH-1:0] ADDR0;
    logic                  LOCK0;
    logic                  GNT0;
    logic                  RVALID0;
    logic [DATA_WIDTH-1:0] RDATA0;

    logic                  REQ1;
    logic [ADDR_WIDTH-1:0] ADDR1;
    logic                  LOCK1;
    logic                  GNT1;
    logic                  RVALID1;
    logic [DATA_WIDTH-1:0] RDATA1;

    logic [ADDR_WIDTH-1:0] ROM_ADDR;
    logic [DATA_WIDTH-1:0] ROM_DATA;
    logic                  BUSY;

    modport master (
        output REQ0, ADDR0, LOCK0, REQ1, ADDR1, LOCK1, ROM_DATA,
        input  GNT0, RVALID0, RDATA0, GNT1, RVALID1, RDATA1, ROM_ADDR, BUSY
    );

    modport slave (
        input  REQ0, ADDR0, LOCK0, REQ1, ADDR1, LOCK1, ROM_DATA,
        output GNT0, RVALID0, RDATA0, GNT1, RVALID1, RDATA1, ROM_ADDR, BUSY
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of the single-port program ROM: round-robin or fixed
// priority, bounded bursts via LOCKx, in-order read data returned to the owning port.
module rom_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ROM_LATENCY = 1,
    parameter int unsigned FIXED_PRIO  = 0,
    parameter int unsigned MAX_LOCK    = 16
) (
    input  logic         CLK,
    input  logic         RESETN,
    rom_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   last_gnt_q;
    logic [CNT_W-1:0]       lock_cnt_q;
    logic [ADDR_WIDTH-1:0]  last_addr_q;
    logic [ROM_LATENCY-1:0] vld_q;
    logic [ROM_LATENCY-1:0] pid_q;

    logic                   gnt0_c;
    logic                   gnt1_c;
    logic                   acc_c;
    logic                   tie0_c;
    logic                   gnt_lock_c;
    logic [CNT_W-1:0]       cnt_next_c;
    logic                   max_hit_c;
    logic [DATA_WIDTH-1:0]  rdata_c;

    // Grant selection; port 0 wins a tie under fixed priority or when port 1 was served last
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        tie0_c = (FIXED_PRIO != 0) || last_gnt_q;
        case (state_q)
            IDLE: begin
                gnt0_c = bus.REQ0 & (~bus.REQ1 | tie0_c);
                gnt1_c = bus.REQ1 & ~gnt0_c;
            end
            LOCKED0: gnt0_c = bus.REQ0;
            LOCKED1: gnt1_c = bus.REQ1;
            default: ;
        endcase
        if (!RESETN) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end
    end

    assign acc_c      = gnt0_c | gnt1_c;
    assign gnt_lock_c = gnt0_c ? bus.LOCK0 : bus.LOCK1;
    assign cnt_next_c = (state_q == IDLE) ? CNT_W'(1) : lock_cnt_q + CNT_W'(1);
    assign max_hit_c  = cnt_next_c >= CNT_W'(MAX_LOCK);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            lock_cnt_q  <= '0;
            last_addr_q <= '0;
            vld_q       <= '0;
            pid_q       <= '0;
        end else begin
            if (acc_c) begin
                last_addr_q <= gnt0_c ? bus.ADDR0 : bus.ADDR1;
                last_gnt_q  <= gnt1_c;
            end
            // Return pipeline mirrors the ROM latency: {valid, port id} per accepted read
            vld_q <= ROM_LATENCY'({vld_q, acc_c});
            pid_q <= ROM_LATENCY'({pid_q, gnt1_c});

            case (state_q)
                IDLE: begin
                    if (acc_c && gnt_lock_c && !max_hit_c) begin
                        state_q    <= gnt0_c ? LOCKED0 : LOCKED1;
                        lock_cnt_q <= cnt_next_c;
                    end
                end
                LOCKED0: begin
                    if (!bus.REQ0 || !bus.LOCK0 || max_hit_c) begin
                        state_q    <= IDLE;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= cnt_next_c;
                    end
                end
                LOCKED1: begin
                    if (!bus.REQ1 || !bus.LOCK1 || max_hit_c) begin
                        state_q    <= IDLE;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= cnt_next_c;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end

    assign rdata_c = bus.ROM_DATA;

    assign bus.GNT0     = gnt0_c;
    assign bus.GNT1     = gnt1_c;
    // Address is held between grants so the ROM input stays quiet while idle
    assign bus.ROM_ADDR = gnt0_c ? bus.ADDR0 : (gnt1_c ? bus.ADDR1 : last_addr_q);
    assign bus.RVALID0  = vld_q[ROM_LATENCY-1] & ~pid_q[ROM_LATENCY-1];
    assign bus.RVALID1  = vld_q[ROM_LATENCY-1] &  pid_q[ROM_LATENCY-1];
    assign bus.RDATA0   = rdata_c;
    assign bus.RDATA1   = rdata_c;
    assign bus.BUSY     = (state_q != IDLE) | (|vld_q);
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a round-robin instance with a ROM model and read-data scoreboard,
// plus a fixed-priority MAX_LOCK=1 instance for grant-only checks.
module tb_rom_arbiter;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned LAT = 1;

    logic CLK = 1'b0;
    logic RESETN;
    always #5 CLK = ~CLK;

    rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    rom_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT), .FIXED_PRIO(0), .MAX_LOCK(16)
    ) dut_a (.CLK(CLK), .RESETN(RESETN), .bus(bus_a.slave));

    rom_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT), .FIXED_PRIO(1), .MAX_LOCK(1)
    ) dut_b (.CLK(CLK), .RESETN(RESETN), .bus(bus_b.slave));

    // ROM model: address sampled on the rising edge, data LAT cycles later
    logic [DW-1:0] image    [256];
    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge CLK) begin
        rom_pipe[0] <= image[bus_a.ROM_ADDR];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus_a.ROM_DATA = rom_pipe[LAT-1];
    assign bus_b.ROM_DATA = '0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: {port, data} pushed on each grant, popped on each RVALID
    logic [8:0]    sb [$];
    logic [8:0]    sb_e;
    logic [AW-1:0] last_addr;
    int            rv0_cnt = 0;
    int            rv1_cnt = 0;

    always @(negedge CLK) begin
        if (!RESETN) begin
            sb.delete();
            last_addr = '0;
        end else begin
            if (bus_a.RVALID0 || bus_a.RVALID1) begin
                if (bus_a.RVALID0) rv0_cnt++;
                if (bus_a.RVALID1) rv1_cnt++;
                if (sb.size() == 0) begin
                    check("rvalid_spurious", 32'({bus_a.RVALID1, bus_a.RVALID0}), 0);
                end else begin
                    sb_e = sb.pop_front();
                    check("rvalid_port", 32'({bus_a.RVALID1, bus_a.RVALID0}), sb_e[8] ? 2 : 1);
                    check("rdata", 32'(sb_e[8] ? bus_a.RDATA1 : bus_a.RDATA0), 32'(sb_e[7:0]));
                end
            end
            check("gnt_onehot", 32'(bus_a.GNT0 & bus_a.GNT1), 0);
            if (bus_a.GNT0) begin
                check("rom_addr_gnt0", 32'(bus_a.ROM_ADDR), 32'(bus_a.ADDR0));
                sb.push_back({1'b0, image[bus_a.ADDR0]});
                last_addr = bus_a.ADDR0;
            end else if (bus_a.GNT1) begin
                check("rom_addr_gnt1", 32'(bus_a.ROM_ADDR), 32'(bus_a.ADDR1));
                sb.push_back({1'b1, image[bus_a.ADDR1]});
                last_addr = bus_a.ADDR1;
            end else begin
                check("rom_addr_idle", 32'(bus_a.ROM_ADDR), 32'(last_addr));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_a();
        bus_a.REQ0 = 1'b0; bus_a.ADDR0 = '0; bus_a.LOCK0 = 1'b0;
        bus_a.REQ1 = 1'b0; bus_a.ADDR1 = '0; bus_a.LOCK1 = 1'b0;
    endtask

    task automatic idle_b();
        bus_b.REQ0 = 1'b0; bus_b.ADDR0 = '0; bus_b.LOCK0 = 1'b0;
        bus_b.REQ1 = 1'b0; bus_b.ADDR1 = '0; bus_b.LOCK1 = 1'b0;
    endtask

    task automatic sample_gnt_a(input string tag, input logic e0, input logic e1);
        @(negedge CLK);
        check({tag, "_gnt0"}, 32'(bus_a.GNT0), 32'(e0));
        check({tag, "_gnt1"}, 32'(bus_a.GNT1), 32'(e1));
    endtask

    task automatic sample_gnt_b(input string tag, input logic e0, input logic e1);
        @(negedge CLK);
        check({tag, "_gnt0"}, 32'(bus_b.GNT0), 32'(e0));
        check({tag, "_gnt1"}, 32'(bus_b.GNT1), 32'(e1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0_base;
        int rv1_base;
        for (int i = 0; i < 256; i++) image[i] = DW'((i * 37 + 11) ^ (i >> 2));

        RESETN = 1'b0;
        idle_a();
        idle_b();
        repeat (2) tick();
        @(negedge CLK);
        check("rst_rom_addr", 32'(bus_a.ROM_ADDR), 0);
        check("rst_busy", 32'(bus_a.BUSY), 0);
        check("rst_rvalid", 32'({bus_a.RVALID1, bus_a.RVALID0}), 0);
        tick();
        RESETN = 1'b1;

        // Single-port sweep with address wrap back to 0x00
        rv0_base = rv0_cnt;
        rv1_base = rv1_cnt;
        for (int a = 0; a <= 256; a++) begin
            bus_a.REQ0  = 1'b1;
            bus_a.ADDR0 = AW'(a);
            sample_gnt_a("sweep", 1'b1, 1'b0);
            tick();
        end
        idle_a();
        repeat (LAT + 2) tick();
        check("sweep_rv0_count", rv0_cnt - rv0_base, 257);
        check("sweep_rv1_count", rv1_cnt - rv1_base, 0);
        @(negedge CLK);
        check("sweep_busy_done", 32'(bus_a.BUSY), 0);
        tick();

        // Reset with a read in flight; REQ0 stays high through reset
        bus_a.REQ0  = 1'b1;
        bus_a.ADDR0 = 8'h42;
        sample_gnt_a("pre_rst", 1'b1, 1'b0);
        @(posedge CLK);
        #1;
        RESETN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("inrst_rom_addr", 32'(bus_a.ROM_ADDR), 0);
            check("inrst_busy", 32'(bus_a.BUSY), 0);
            check("inrst_rvalid0", 32'(bus_a.RVALID0), 0);
            check("inrst_gnt0", 32'(bus_a.GNT0), 0);
            tick();
        end
        RESETN = 1'b1;

        // Round-robin tie right after reset: port 0 first
        bus_a.ADDR0 = 8'h10;
        bus_a.REQ1  = 1'b1;
        bus_a.ADDR1 = 8'h20;
        for (int i = 0; i < 8; i++) begin
            sample_gnt_a("rr", (i % 2) == 0, (i % 2) == 1);
            if (i == 0) check("post_rst_rvalid0", 32'(bus_a.RVALID0), 0);
            tick();
        end
        idle_a();
        repeat (LAT + 2) tick();

        // Lock for three accesses, release on the fourth, port 1 waiting
        for (int i = 0; i < 5; i++) begin
            bus_a.REQ0  = 1'b1;
            bus_a.ADDR0 = AW'(8'h30 + ((i < 4) ? i : 3) + ((i == 4) ? 1 : 0));
            bus_a.LOCK0 = (i < 3);
            bus_a.REQ1  = 1'b1;
            bus_a.ADDR1 = 8'h40;
            sample_gnt_a("lockrel", i < 4, i == 4);
            tick();
        end
        idle_a();
        repeat (LAT + 2) tick();

        // Lock timeout at MAX_LOCK=16, then port 1, then port 0 again
        for (int i = 0; i < 18; i++) begin
            bus_a.REQ0  = 1'b1;
            bus_a.LOCK0 = 1'b1;
            bus_a.ADDR0 = AW'(8'h60 + ((i < 16) ? i : 16));
            bus_a.REQ1  = 1'b1;
            bus_a.ADDR1 = (i < 17) ? 8'h55 : 8'h56;
            sample_gnt_a("locktmo", i != 16, i == 16);
            if (i == 8) check("lock_busy", 32'(bus_a.BUSY), 1);
            tick();
        end
        idle_a();
        repeat (LAT + 3) tick();
        @(negedge CLK);
        check("final_busy", 32'(bus_a.BUSY), 0);
        check("sb_drained", sb.size(), 0);
        tick();

        // Fixed priority: port 1 waits until REQ0 drops
        for (int i = 0; i < 5; i++) begin
            bus_b.REQ0  = (i < 4);
            bus_b.ADDR0 = AW'(i);
            bus_b.REQ1  = 1'b1;
            bus_b.ADDR1 = 8'h80;
            sample_gnt_b("fixed", i < 4, i == 4);
            tick();
        end
        // MAX_LOCK=1: a locked grant releases immediately
        bus_b.REQ0 = 1'b0; bus_b.REQ1 = 1'b1; bus_b.LOCK1 = 1'b1; bus_b.ADDR1 = 8'h81;
        sample_gnt_b("maxlock1_a", 1'b0, 1'b1);
        tick();
        bus_b.REQ0 = 1'b1; bus_b.ADDR0 = 8'h90; bus_b.ADDR1 = 8'h82;
        sample_gnt_b("maxlock1_b", 1'b1, 1'b0);
        tick();
        bus_b.REQ0 = 1'b0;
        sample_gnt_b("maxlock1_c", 1'b0, 1'b1);
        tick();
        idle_b();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single-port 256x8 program ROM between two requesters: port 0 is the CPU instruction fetch and port 1 is the demo/debug reader.
- Sits directly in front of the ROM block. The ROM samples its address on a CLK rising edge and presents the data ROM_LATENCY cycles later.
- Provides round-robin or fixed-priority arbitration, optional bounded locking for bursts, and in-order return of read data to the owning port.

Parameters:
- ADDR_WIDTH, 8, ROM address width.
- DATA_WIDTH, 8, ROM data width.
- ROM_LATENCY, 1, cycles from address acceptance to valid ROM DATA. Legal range 1 to 4.
- FIXED_PRIO, 0. 0 selects round-robin; 1 means port 0 always wins ties.
- MAX_LOCK, 16, maximum consecutive grants to a locked port before forced release. Legal range 1 to 255.

Ports:
- CLK  in  1  system clock, all state on its rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- REQ0  in  1  port 0 read request.
- ADDR0  in  ADDR_WIDTH  port 0 address.
- LOCK0  in  1  port 0 requests to keep the grant after this access.
- GNT0  out  1  port 0 request accepted this cycle.
- RVALID0  out  1  RDATA0 valid this cycle.
- RDATA0  out  DATA_WIDTH  port 0 read data.
- REQ1, ADDR1, LOCK1, GNT1, RVALID1, RDATA1: same as port 0, for port 1.
- ROM_ADDR  out  ADDR_WIDTH  drives ROM ADDR.
- ROM_DATA  in  DATA_WIDTH  from ROM DATA.
- BUSY  out  1  high while any access is in flight or a lock is held.

Behaviour:
Reset (RESETN low, asynchronous):
- GNT0/1=0, RVALID0/1=0, BUSY=0.
- ROM_ADDR=0: the last-address register is cleared.
- In-flight pipeline is cleared and the state machine goes to IDLE.
- Round-robin pointer last_gnt=1, so port 0 wins the first tie.
- Lock counter=0.

Handshake:
- GNTx is combinational from REQx and the arbiter state. At most one GNT is high per cycle.
- An access is accepted on the rising edge where REQx&GNTx=1.
- A requester holds REQx/ADDRx/LOCKx stable until it sees GNTx.
- One acceptance per cycle, fully pipelined, no bubbles.

ROM address:
- ROM_ADDR = ADDR of the granted port in the grant cycle.
- When nothing is granted, ROM_ADDR holds the last accepted address; it must not toggle while idle.

Return path:
- A ROM_LATENCY-deep shift register carries {valid, port id}.
- An access accepted in cycle N gives RVALIDx=1 for exactly one cycle, in cycle N+ROM_LATENCY.
- RDATAx = ROM_DATA, passed through. Both RDATA ports carry ROM_DATA; only the matching RVALID is asserted.
- Data returns in order. Throughput is one read per cycle.

State machine: IDLE, LOCKED0, LOCKED1.
- IDLE:
  - If only one port requests, grant it.
  - If both request and FIXED_PRIO=1, grant port 0.
  - If both request and FIXED_PRIO=0, grant the port != last_gnt.
  - last_gnt updates only on acceptance.
  - Acceptance with LOCKx=1 goes to LOCKEDx and sets the lock counter to 1.
- LOCKEDx:
  - Only port x can be granted; the other port's GNT stays 0.
  - Each acceptance with LOCKx=1 increments the counter.
  - Go to IDLE on any of: acceptance with LOCKx=0; a cycle with REQx=0; the counter reaching MAX_LOCK on an acceptance.
  - On forced release at MAX_LOCK, last_gnt=x, so the other port wins the next tie.

BUSY = (state!=IDLE) | any pipeline valid bit.

Boundary conditions:
- Address wrap: 0xFF then 0x00 is legal; addresses are not interpreted.
- Simultaneous REQ with an RVALID return: independent, both occur in the same cycle.
- Reset asserted mid-flight: pending RVALIDs are dropped and never emitted after reset release.
- LOCKx=1 with MAX_LOCK=1: one grant, then immediate release.

Test Plan:
1. Single port sweep: port 0 requests ADDR 0x00..0xFF back-to-back with port 1 idle -> GNT0 high every cycle; RVALID0 high from cycle 1 through 256 after the first acceptance; RDATA0 matches the ROM image byte for each address in order; RVALID1 never high.
2. Round-robin tie: both ports request continuously (port 0 at 0x10, port 1 at 0x20), FIXED_PRIO=0 -> grants alternate 0,1,0,1 starting with port 0; RVALID0/1 alternate ROM_LATENCY cycles later with image[0x10]/image[0x20].
3. Fixed priority: FIXED_PRIO=1, both requesting -> GNT1 stays 0 until REQ0 drops; the next cycle gives GNT1=1.
4. Lock with release: port 0 requests with LOCK0=1 for 3 accesses, then LOCK0=0, while port 1 requests throughout -> 4 consecutive GNT0; GNT1 in the 5th cycle.
5. Lock timeout: MAX_LOCK=16, port 0 holds LOCK0=1 and REQ0=1 indefinitely, port 1 requesting -> exactly 16 GNT0, then GNT1=1 in the next cycle, then GNT0 again.
6. Reset mid-operation: RESETN pulled low 1 ns after accepting ADDR 0x42, released 3 cycles later -> no RVALID0 ever for 0x42; ROM_ADDR=0x00 and BUSY=0 during reset; the first post-reset tie goes to port 0.
